// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the 8-to-3 pending encoder.
// Optional feature macro: ROTATE_PRIO_EN (round-robin priority).
package encoder_pkg;

  localparam int ENC_N = 8;
  localparam int ENC_W = 3;

  function automatic logic [ENC_N-1:0] onehot8(
    input logic [ENC_W-1:0] idx
  );
    logic [ENC_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-way priority search starting at base, wrapping.
// With base=0 this is a plain lowest-index-wins encoder.
module prio_enc8
  import encoder_pkg::*;
(
  input  logic [ENC_N-1:0] vec,
  input  logic [ENC_W-1:0] base,
  output logic [ENC_W-1:0] idx,
  output logic             any
);

  logic [ENC_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |vec;
    for (int i = ENC_N - 1; i >= 0; i--) begin
      cand = base + ENC_W'(i);
      if (vec[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/encoder_8to3_pending.sv
// Sequential 8-to-3 encoder with pending register and valid/ready output.
// Define ROTATE_PRIO_EN for round-robin priority; default is fixed priority.
module encoder_8to3_pending
  import encoder_pkg::*;
#(
  parameter int N = ENC_N,
  parameter int W = ENC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_in,
  input  logic         en,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  logic [N-1:0] p_q;
  logic         accept;
  logic [N-1:0] clr;
  logic [N-1:0] set_v;
  logic [N-1:0] remain;
  logic [N-1:0] p_next;
  logic [W-1:0] base;
  logic [W-1:0] nxt_idx;
  logic         nxt_any;

  assign pending = p_q;
  assign accept  = out_valid & out_ready;
  assign clr     = accept ? onehot8(out_idx) : '0;
  assign set_v   = en ? req_in : '0;
  // The presented bit is excluded here, so a re-pended bit waits an edge.
  assign remain  = p_q & ~clr;
  assign p_next  = remain | set_v;

  prio_enc8 u_prio (
    .vec  (remain),
    .base (base),
    .idx  (nxt_idx),
    .any  (nxt_any)
  );

`ifdef ROTATE_PRIO_EN
  logic [W-1:0] last_grant;

  assign base = last_grant + 1'b1;

  // Remember the last accepted index to rotate the search start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= W'(N - 1);
    end else if (accept) begin
      last_grant <= out_idx;
    end
  end
`else
  assign base = '0;
`endif

  // Pending register, output stage and overflow pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      overflow  <= 1'b0;
    end else begin
      p_q      <= p_next;
      overflow <= |(set_v & remain);
      if (!out_valid || accept) begin
        out_valid <= nxt_any;
        out_idx   <= nxt_idx;
      end
    end
  end

endmodule

// File: tb/tb_encoder_8to3_pending.sv
// Directed self-checking bench for encoder_8to3_pending.
// Build with or without ROTATE_PRIO_EN; expectations follow the mode.
module tb_encoder_8to3_pending;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req_in;
  logic       en;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_fails  = 0;

  int exp5b [6];

  always #5 clk = ~clk;

  encoder_8to3_pending dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .en        (en),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .overflow  (overflow)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
`ifdef ROTATE_PRIO_EN
    exp5b = '{0, 1, 2, 0, 1, 2};
`else
    exp5b = '{0, 1, 0, 1, 0, 1};
`endif
    reset     = 1'b1;
    req_in    = '0;
    en        = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_pend", pending, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;

    // 1: two bits captured in one cycle, drained in index order
    en = 1; req_in = 8'b0010_0100; out_ready = 1;
    step();
    en = 0; req_in = 0;
    check("t1_pend", pending, 8'h24);
    check("t1_v0", out_valid, 0);
    step();
    check("t1_v1", out_valid, 1);
    check("t1_i2", out_idx, 2);
    step();
    check("t1_v2", out_valid, 1);
    check("t1_i5", out_idx, 5);
    step();
    check("t1_empty_v", out_valid, 0);
    check("t1_empty_p", pending, 0);

    // 2: en low masks requests
    en = 0; req_in = 8'hFF;
    step();
    step();
    check("t2_pend", pending, 0);
    check("t2_valid", out_valid, 0);
    req_in = 0;

    // 3: stall holds the output; repeat request pulses overflow
    out_ready = 0; en = 1; req_in = 8'h08;
    step();
    en = 0; req_in = 0;
    check("t3_pend", pending, 8'h08);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        en = 1; req_in = 8'h08;
      end
      step();
      en = 0; req_in = 0;
      check("t3_hold_v", out_valid, 1);
      check("t3_hold_i", out_idx, 3);
      check("t3_ovf", overflow, (i == 1) ? 1 : 0);
    end
    out_ready = 1;
    step();
    check("t3_acc_v", out_valid, 0);
    check("t3_acc_p", pending, 0);

    // 4: request on the accept edge re-pends the bit
    out_ready = 0; en = 1; req_in = 8'h40;
    step();
    en = 0; req_in = 0;
    step();
    check("t4_pres_i", out_idx, 6);
    check("t4_pres_v", out_valid, 1);
    out_ready = 1; en = 1; req_in = 8'h40;
    step();
    en = 0; req_in = 0;
    check("t4_repend_p", pending, 8'h40);
    check("t4_repend_v", out_valid, 0);
    check("t4_no_ovf", overflow, 0);
    step();
    check("t4_again_v", out_valid, 1);
    check("t4_again_i", out_idx, 6);
    step();
    check("t4_drain_v", out_valid, 0);
    check("t4_drain_p", pending, 0);

    // 5a: held 0x81 alternates since the just-accepted bit waits an edge
    do_reset();
    out_ready = 1; en = 1; req_in = 8'h81;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5a_v", out_valid, 1);
      check("t5a_i", out_idx, (i % 2 == 0) ? 0 : 7);
    end
    en = 0; req_in = 0;
    step();
    step();
    step();
    check("t5a_drain_v", out_valid, 0);
    check("t5a_drain_p", pending, 0);

    // 5b: held 0x07 shows fixed starvation vs round-robin
    do_reset();
    out_ready = 1; en = 1; req_in = 8'h07;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5b_v", out_valid, 1);
      check("t5b_i", out_idx, exp5b[i]);
    end
    en = 0; req_in = 0;
    for (int i = 0; i < 5; i++) step();
    check("t5b_drain_v", out_valid, 0);
    check("t5b_drain_p", pending, 0);

    // 6: async reset mid-transfer clears everything at once
    out_ready = 0; en = 1; req_in = 8'hF0;
    step();
    en = 0; req_in = 0;
    step();
    check("t6_pre_v", out_valid, 1);
    check("t6_pre_i", out_idx, 4);
    check("t6_pre_p", pending, 8'hF0);
    out_ready = 1;
    #2;
    reset = 1;
    #1;
    check("t6_rst_v", out_valid, 0);
    check("t6_rst_i", out_idx, 0);
    check("t6_rst_p", pending, 0);
    check("t6_rst_o", overflow, 0);
    step();
    check("t6_hold_v", out_valid, 0);
    check("t6_hold_p", pending, 0);
    reset = 0;
    en = 1; req_in = 8'h81;
    step();
    en = 0; req_in = 0;
    step();
    check("t6_first_v", out_valid, 1);
    check("t6_first_i", out_idx, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
